// File: rtl/cnn_layer_accel_result_pkg.sv
// Shared types for the CNN result packer: FSM states, packed output word, lane-mask helper.
// Lane i of a word holds the i-th result of that word, little-endian in the data field.
package cnn_layer_accel_result_pkg;

  localparam int RESULT_W = 16;
  localparam int OUT_W    = 128;
  localparam int LANES    = OUT_W / RESULT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] keep;
    logic             last;
  } out_word_t;

  function automatic logic [LANES-1:0] keep_mask(input int n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (i < n);
    return m;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_word_fifo.sv
// Synchronous FIFO of packed output words; head visible combinationally, push/pop same cycle keeps count.
// A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module cnn_layer_accel_word_fifo
  import cnn_layer_accel_result_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_core,
  input  logic          rst,
  input  logic          push_vld,
  input  out_word_t     push_dat,
  input  logic          pop_rdy,
  output out_word_t     head_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  out_word_t     mem_q [DEPTH];
  out_word_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop_rdy && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the accelerator's 16-bit result stream into 128-bit words, flushing a partial word per output row.
// One cycle from completing result to out_valid; result_accept drops while the word FIFO is full.
module cnn_layer_accel_result_packer #(
  parameter int RESULT_W   = 16,
  parameter int OUT_W      = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk_core,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic [9:0]                num_output_rows_cfg,
  input  logic [9:0]                num_output_cols_cfg,
  input  logic [6:0]                num_kernel_cfg,
  output logic                      busy,
  output logic                      cfg_err,
  input  logic                      result_valid,
  output logic                      result_accept,
  input  logic [RESULT_W-1:0]       result_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [OUT_W/RESULT_W-1:0] out_keep,
  output logic                      out_last,
  output logic [9:0]                output_row,
  output logic [9:0]                output_col,
  output logic [6:0]                output_depth,
  output logic                      job_done
);
  import cnn_layer_accel_result_pkg::*;

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t           state_q, state_d;
  logic [9:0]       rows_q, rows_d, cols_q, cols_d;
  logic [6:0]       kern_q, kern_d;
  logic [9:0]       row_q, row_d, col_q, col_d;
  logic [6:0]       depth_q, depth_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [OUT_W-1:0] pack_q, pack_d, pack_next;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;
  logic             job_done_q, job_done_d;

  out_word_t        push_word, head_word;
  logic             push_vld, pop, fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             res_hs, cfg_ok;
  logic             depth_last, col_last, row_last, row_end, job_end, lane_full;

  assign cfg_ok     = (num_output_rows_cfg != '0) && (num_output_cols_cfg != '0) && (num_kernel_cfg != '0);
  assign depth_last = (depth_q == kern_q - 7'd1);
  assign col_last   = (col_q == cols_q - 10'd1);
  assign row_last   = (row_q == rows_q - 10'd1);
  assign row_end    = depth_last && col_last;
  assign job_end    = row_end && row_last;
  assign lane_full  = (lane_q == LW'(LANES - 1));

  assign result_accept = (state_q == RUN) && (fifo_count < CW'(FIFO_DEPTH));
  assign res_hs        = result_accept && result_valid;
  assign out_valid     = !fifo_empty;
  assign pop           = out_valid && out_ready;

  // Head storage may hold stale words once drained; only expose it while valid.
  assign out_data = out_valid ? head_word.data : '0;
  assign out_keep = out_valid ? head_word.keep : '0;
  assign out_last = out_valid && head_word.last;

  assign busy         = busy_q;
  assign cfg_err      = cfg_err_q;
  assign job_done     = job_done_q;
  assign output_row   = row_q;
  assign output_col   = col_q;
  assign output_depth = depth_q;

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    kern_d     = kern_q;
    row_d      = row_q;
    col_d      = col_q;
    depth_d    = depth_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    cfg_err_d  = cfg_err_q;
    job_done_d = 1'b0;
    push_vld   = 1'b0;
    push_word  = '0;
    pack_next  = pack_q;
    pack_next[lane_q*RESULT_W +: RESULT_W] = result_data;

    case (state_q)
      IDLE: begin
        if (job_start) begin
          if (cfg_ok) begin
            rows_d    = num_output_rows_cfg;
            cols_d    = num_output_cols_cfg;
            kern_d    = num_kernel_cfg;
            row_d     = '0;
            col_d     = '0;
            depth_d   = '0;
            lane_d    = '0;
            pack_d    = '0;
            cfg_err_d = 1'b0;
            state_d   = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (res_hs) begin
          if (lane_full || row_end) begin
            push_vld       = 1'b1;
            push_word.data = pack_next;
            push_word.keep = keep_mask(int'(lane_q) + 1);
            push_word.last = job_end;
            pack_d         = '0;
            lane_d         = '0;
          end else begin
            pack_d = pack_next;
            lane_d = lane_q + 1'b1;
          end
          // Depth runs fastest, then column, then row.
          if (depth_last) begin
            depth_d = '0;
            if (col_last) begin
              col_d = '0;
              row_d = row_last ? 10'd0 : row_q + 10'd1;
            end else begin
              col_d = col_q + 10'd1;
            end
          end else begin
            depth_d = depth_q + 7'd1;
          end
          if (job_end) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_word.last) begin
          state_d    = IDLE;
          job_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      kern_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      depth_q    <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      cfg_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      kern_q     <= kern_d;
      row_q      <= row_d;
      col_q      <= col_d;
      depth_q    <= depth_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      cfg_err_q  <= cfg_err_d;
      busy_q     <= busy_d;
      job_done_q <= job_done_d;
    end
  end

  cnn_layer_accel_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_word_fifo (
    .clk_core (clk_core),
    .rst      (rst),
    .push_vld (push_vld),
    .push_dat (push_word),
    .pop_rdy  (pop),
    .head_dat (head_word),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed job sequence with random result data and handshakes, checked against a row-chunking word model.
module tb_cnn_layer_accel_result_packer;

  logic         clk_core = 1'b0;
  logic         rst;
  logic         job_start;
  logic [9:0]   num_output_rows_cfg;
  logic [9:0]   num_output_cols_cfg;
  logic [6:0]   num_kernel_cfg;
  logic         busy, cfg_err;
  logic         result_valid, result_accept;
  logic [15:0]  result_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_keep;
  logic         out_last;
  logic [9:0]   output_row, output_col;
  logic [6:0]   output_depth;
  logic         job_done;
  logic [191:0] outs_all;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_core = ~clk_core;

  cnn_layer_accel_result_packer dut (
    .clk_core            (clk_core),
    .rst                 (rst),
    .job_start           (job_start),
    .num_output_rows_cfg (num_output_rows_cfg),
    .num_output_cols_cfg (num_output_cols_cfg),
    .num_kernel_cfg      (num_kernel_cfg),
    .busy                (busy),
    .cfg_err             (cfg_err),
    .result_valid        (result_valid),
    .result_accept       (result_accept),
    .result_data         (result_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_keep            (out_keep),
    .out_last            (out_last),
    .output_row          (output_row),
    .output_col          (output_col),
    .output_depth        (output_depth),
    .job_done            (job_done)
  );

  assign outs_all = {23'd0, busy, cfg_err, result_accept, out_valid, out_data, out_keep, out_last,
                     output_row, output_col, output_depth, job_done};

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vmode: 0 valid always, 1 random. rmode: 0 ready always, 1 random, 2 low for the first 40 cycles.
  task automatic run_job(input int R, input int C, input int K, input int vmode, input int rmode,
                         input bit seq, input int abort_after, input bit poke);
    logic [15:0]  vals[$];
    logic [136:0] expw[$];
    logic [136:0] gotw[$];
    logic [136:0] cur, prev_out;
    int total, per_row, acc, cyc, stop_at;
    bit last_hs, prev_stall, poked, hs_in, hs_out;
    total      = R * C * K;
    per_row    = C * K;
    acc        = 0;
    cyc        = 0;
    last_hs    = 1'b0;
    prev_stall = 1'b0;
    poked      = 1'b0;
    prev_out   = '0;
    stop_at    = (abort_after > 0) ? abort_after : total;
    for (int i = 0; i < total; i++) vals.push_back(seq ? 16'(i + 1) : 16'($urandom));

    // Each row's C*K results are cut into 8-lane chunks; the final chunk of the final row is last.
    for (int r = 0; r < R; r++) begin
      for (int s = 0; s < per_row; s += 8) begin
        logic [127:0] d;
        logic [7:0]   k;
        d = '0;
        k = '0;
        for (int j = 0; j < 8 && s + j < per_row; j++) begin
          d[j*16 +: 16] = vals[r*per_row + s + j];
          k[j] = 1'b1;
        end
        expw.push_back({d, k, (r == R - 1) && (s + 8 >= per_row)});
      end
    end

    @(negedge clk_core);
    num_output_rows_cfg = 10'(R);
    num_output_cols_cfg = 10'(C);
    num_kernel_cfg      = 7'(K);
    job_start           = 1'b1;
    @(negedge clk_core);
    job_start = 1'b0;
    #1;
    check("start_busy", 192'(busy), 192'(1));
    check("start_cfg_err", 192'(cfg_err), 192'(0));
    check("start_pos", 192'({output_row, output_col, output_depth}), 192'(0));

    forever begin
      if (abort_after > 0 && acc == abort_after) break;
      result_valid = (acc < stop_at) && (vmode == 0 || $urandom_range(0, 3) != 0);
      result_data  = (acc < total) ? vals[acc] : 16'($urandom);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 40);
      endcase
      if (poke && !poked && acc == 3) begin
        job_start           = 1'b1;
        num_output_rows_cfg = 10'd7;
        num_output_cols_cfg = 10'd1;
        num_kernel_cfg      = 7'd1;
        poked               = 1'b1;
      end else begin
        job_start = 1'b0;
      end
      #1;
      check("job_done", 192'(job_done), 192'(last_hs));
      if (last_hs) begin
        check("end_busy", 192'(busy), 192'(0));
        break;
      end
      if (prev_stall)
        check("hold_stable", 192'({out_valid, out_data, out_keep, out_last}), 192'({1'b1, prev_out}));
      if (rmode == 2 && cyc == 39) begin
        check("stall_accept", 192'(result_accept), 192'(0));
        check("stall_count", 192'(acc), 192'(16));
      end
      hs_in = result_valid && result_accept;
      if (hs_in)
        check("pos", 192'({output_row, output_col, output_depth}),
              192'({10'(acc / per_row), 10'((acc / K) % C), 7'(acc % K)}));
      hs_out     = out_valid && out_ready;
      cur        = {out_data, out_keep, out_last};
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      @(posedge clk_core);
      if (hs_in) acc++;
      if (hs_out) gotw.push_back(cur);
      last_hs = hs_out && cur[0];
      cyc++;
      if (cyc > 4000) begin
        check("timeout", 192'(cyc), 192'(0));
        break;
      end
      @(negedge clk_core);
    end

    result_valid = 1'b0;
    job_start    = 1'b0;
    if (abort_after == 0) begin
      check("nwords", 192'(gotw.size()), 192'(expw.size()));
      foreach (expw[i])
        if (i < gotw.size()) check($sformatf("word%0d", i), 192'(gotw[i]), 192'(expw[i]));
      @(negedge clk_core);
      #1;
      check("done_pulse_end", 192'(job_done), 192'(0));
    end
  endtask

  initial begin
    rst                 = 1'b1;
    job_start           = 1'b0;
    num_output_rows_cfg = '0;
    num_output_cols_cfg = '0;
    num_kernel_cfg      = '0;
    result_valid        = 1'b0;
    result_data         = '0;
    out_ready           = 1'b0;
    #3;
    check("reset_outs", outs_all, 192'(0));
    repeat (2) @(negedge clk_core);
    rst = 1'b0;

    run_job(1, 1, 8, 0, 0, 1'b1, 0, 1'b0);
    run_job(2, 3, 3, 1, 1, 1'b0, 0, 1'b0);
    run_job(1, 4, 8, 0, 2, 1'b0, 0, 1'b0);

    @(negedge clk_core);
    num_output_rows_cfg = 10'd2;
    num_output_cols_cfg = 10'd2;
    num_kernel_cfg      = 7'd0;
    job_start           = 1'b1;
    @(negedge clk_core);
    job_start = 1'b0;
    #1;
    check("cfg_err_set", 192'(cfg_err), 192'(1));
    check("cfg_err_busy", 192'(busy), 192'(0));
    check("cfg_err_accept", 192'(result_accept), 192'(0));
    run_job(1, 2, 2, 0, 0, 1'b0, 0, 1'b0);

    run_job(1, 2, 8, 0, 0, 1'b0, 5, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midjob_reset_outs", outs_all, 192'(0));
    @(negedge clk_core);
    rst = 1'b0;
    run_job(1, 1, 3, 0, 0, 1'b0, 0, 1'b0);

    run_job(2, 2, 5, 1, 0, 1'b0, 0, 1'b1);
    run_job(3, 5, 7, 1, 1, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
